// File: rtl/pipe_spawn_scheduler_pkg.sv
// Shared definitions for the pipe spawn scheduler: FSM encoding, LFSR polynomial,
// slot count and coordinate width.
package pipe_spawn_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GAP    = 2'd1,
        ST_SELECT = 2'd2,
        ST_REQ    = 2'd3
    } spawn_state_e;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam int          NUM_SLOTS = 3;
    localparam int          SLOT_W    = 2;
    localparam int          COORD_W   = 10;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift, feedback mask from the package).
// Advances on every clock; SEED must be nonzero.
module lfsr16
    import pipe_spawn_scheduler_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetN,
    output logic [15:0] state_o
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = {1'b0, state_q[15:1]};
        if (state_q[0]) begin
            state_d = state_d ^ LFSR_POLY;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/pipe_spawn_scheduler.sv
// Producer side of the pipe spawn handshake: timed, LFSR-placed spawn requests.
// Optional manual spawn (mouse1/pointY) is enabled by defining PIPE_SPAWN_MANUAL_EN.
module pipe_spawn_scheduler
    import pipe_spawn_scheduler_pkg::*;
#(
    parameter int unsigned BASE_GAP    = 600,
    parameter int unsigned MIN_GAP     = 180,
    parameter int unsigned GAP_STEP    = 12,
    parameter int unsigned FIRST_DELAY = 120,
    parameter int unsigned Y_MIN       = 112,
    parameter int unsigned Y_SPAN_BITS = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 animationCLOCK,
    input  logic                 resetN,
    input  logic                 enable,
    input  logic [9:0]           score,
    input  logic [NUM_SLOTS-1:0] slotBusy,
    input  logic                 spawnAck,
`ifdef PIPE_SPAWN_MANUAL_EN
    input  logic                 mouse1,
    input  logic [COORD_W-1:0]   pointY,
`endif
    output logic                 spawnReq,
    output logic [SLOT_W-1:0]    spawnSlot,
    output logic [COORD_W-1:0]   spawnY,
    output logic [9:0]           spawnScore
);

    localparam int unsigned Y_MAX = Y_MIN + (2 ** Y_SPAN_BITS) - 1;

    spawn_state_e        state_q, state_d;
    logic [19:0]         gapCnt_q, gapCnt_d;
    logic                spawnReq_q, spawnReq_d;
    logic [SLOT_W-1:0]   spawnSlot_q, spawnSlot_d;
    logic [COORD_W-1:0]  spawnY_q, spawnY_d;
    logic [9:0]          spawnScore_q, spawnScore_d;
    logic                manualSel_q, manualSel_d;

    logic [15:0]         lfsr;
    logic [COORD_W-1:0]  lfsrY;
    logic                unusedLfsrBits;
    logic                freeFound;
    logic [SLOT_W-1:0]   freeSlot;
    logic                manualRise;
    logic [COORD_W-1:0]  manualY;

    // Interval shrinks with score and saturates at MIN_GAP without underflow.
    function automatic logic [19:0] calc_gap(input logic [9:0] s);
        logic [19:0] prod;
        prod = 20'(s) * 20'(GAP_STEP);
        if (prod >= 20'(BASE_GAP - MIN_GAP)) begin
            return 20'(MIN_GAP);
        end
        return 20'(BASE_GAP) - prod;
    endfunction

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (animationCLOCK),
        .resetN  (resetN),
        .state_o (lfsr)
    );

    assign lfsrY          = COORD_W'(Y_MIN) + COORD_W'(lfsr[Y_SPAN_BITS-1:0]);
    assign unusedLfsrBits = ^lfsr[15:Y_SPAN_BITS];

    always_comb begin
        freeFound = 1'b0;
        freeSlot  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slotBusy[i]) begin
                freeFound = 1'b1;
                freeSlot  = SLOT_W'(i);
            end
        end
    end

`ifdef PIPE_SPAWN_MANUAL_EN
    logic mouse1_q;

    function automatic logic [COORD_W-1:0] clamp_y(input logic [COORD_W-1:0] y);
        if (y < COORD_W'(Y_MIN)) begin
            return COORD_W'(Y_MIN);
        end
        if (y > COORD_W'(Y_MAX)) begin
            return COORD_W'(Y_MAX);
        end
        return y;
    endfunction

    always_ff @(posedge animationCLOCK or negedge resetN) begin
        if (!resetN) begin
            mouse1_q <= 1'b0;
        end else begin
            mouse1_q <= mouse1;
        end
    end

    assign manualRise = mouse1 & ~mouse1_q;
    assign manualY    = clamp_y(pointY);
`else
    assign manualRise = 1'b0;
    assign manualY    = '0;
`endif

    always_comb begin
        state_d      = state_q;
        gapCnt_d     = gapCnt_q;
        spawnReq_d   = spawnReq_q;
        spawnSlot_d  = spawnSlot_q;
        spawnY_d     = spawnY_q;
        spawnScore_d = spawnScore_q;
        manualSel_d  = manualSel_q;

        // Dropping enable abandons any pending request; payload outputs keep their values.
        if (!enable) begin
            state_d     = ST_IDLE;
            gapCnt_d    = '0;
            spawnReq_d  = 1'b0;
            manualSel_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_GAP;
                    gapCnt_d = 20'(FIRST_DELAY);
                end
                ST_GAP: begin
                    if (manualRise) begin
                        state_d     = ST_SELECT;
                        manualSel_d = 1'b1;
                    end else if (gapCnt_q <= 20'd1) begin
                        state_d = ST_SELECT;
                    end else begin
                        gapCnt_d = gapCnt_q - 20'd1;
                    end
                end
                ST_SELECT: begin
                    if (freeFound) begin
                        spawnSlot_d  = freeSlot;
                        spawnY_d     = manualSel_q ? manualY : lfsrY;
                        spawnScore_d = score;
                        spawnReq_d   = 1'b1;
                        manualSel_d  = 1'b0;
                        state_d      = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (spawnAck) begin
                        spawnReq_d = 1'b0;
                        gapCnt_d   = calc_gap(score);
                        state_d    = ST_GAP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge animationCLOCK or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            gapCnt_q     <= '0;
            spawnReq_q   <= 1'b0;
            spawnSlot_q  <= '0;
            spawnY_q     <= '0;
            spawnScore_q <= '0;
            manualSel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gapCnt_q     <= gapCnt_d;
            spawnReq_q   <= spawnReq_d;
            spawnSlot_q  <= spawnSlot_d;
            spawnY_q     <= spawnY_d;
            spawnScore_q <= spawnScore_d;
            manualSel_q  <= manualSel_d;
        end
    end

    assign spawnReq   = spawnReq_q;
    assign spawnSlot  = spawnSlot_q;
    assign spawnY     = spawnY_q;
    assign spawnScore = spawnScore_q;

endmodule

// File: tb/tb_pipe_spawn_scheduler.sv
// Directed bench for pipe_spawn_scheduler; manual-spawn steps run when PIPE_SPAWN_MANUAL_EN is defined.
module tb_pipe_spawn_scheduler;

    logic       animationCLOCK = 1'b0;
    logic       resetN         = 1'b0;
    logic       enable         = 1'b0;
    logic [9:0] score          = '0;
    logic [2:0] slotBusy       = '0;
    logic       spawnAck       = 1'b0;
`ifdef PIPE_SPAWN_MANUAL_EN
    logic       mouse1         = 1'b0;
    logic [9:0] pointY         = '0;
`endif
    logic       spawnReq;
    logic [1:0] spawnSlot;
    logic [9:0] spawnY;
    logic [9:0] spawnScore;

    int tests = 0;
    int fails = 0;
    int cyc;
    logic [31:0] lastExpY;

    logic [15:0] ref_lfsr;
    logic [15:0] ref_prev;

    pipe_spawn_scheduler dut (
        .animationCLOCK (animationCLOCK),
        .resetN         (resetN),
        .enable         (enable),
        .score          (score),
        .slotBusy       (slotBusy),
        .spawnAck       (spawnAck),
`ifdef PIPE_SPAWN_MANUAL_EN
        .mouse1         (mouse1),
        .pointY         (pointY),
`endif
        .spawnReq       (spawnReq),
        .spawnSlot      (spawnSlot),
        .spawnY         (spawnY),
        .spawnScore     (spawnScore)
    );

    always #5 animationCLOCK = ~animationCLOCK;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ({1'b0, s[15:1]} ^ 16'hB400) : {1'b0, s[15:1]};
    endfunction

    // Reference LFSR; ref_prev holds the value the DUT saw one edge ago.
    always @(posedge animationCLOCK or negedge resetN) begin
        if (!resetN) begin
            ref_lfsr <= 16'hACE1;
            ref_prev <= 16'hACE1;
        end else begin
            ref_prev <= ref_lfsr;
            ref_lfsr <= lfsr_next(ref_lfsr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge animationCLOCK);
        #1;
    endtask

    task automatic wait_req(input int maxc, output int c);
        c = 0;
        while (!spawnReq && c < maxc) begin
            step(1);
            c++;
        end
    endtask

    task automatic do_ack();
        step(1);
        spawnAck = 1'b1;
        step(1);
        spawnAck = 1'b0;
    endtask

    task automatic check_y(input string tag);
        lastExpY = 32'd112 + 32'(ref_prev[7:0]);
        chk(tag, 32'(spawnY), lastExpY);
        chk({tag, "_range"}, 32'(spawnY >= 10'd112 && spawnY <= 10'd367), 32'd1);
    endtask

    initial begin
        #2;
        chk("rst_req",   32'(spawnReq),   32'd0);
        chk("rst_slot",  32'(spawnSlot),  32'd0);
        chk("rst_y",     32'(spawnY),     32'd0);
        chk("rst_score", 32'(spawnScore), 32'd0);
        #10 resetN = 1'b1;
        step(2);

        // 1) first spawn after FIRST_DELAY, then base interval at score 0
        enable = 1'b1;
        step(1);
        wait_req(300, cyc);
        chk("t1_first_latency", 32'(cyc), 32'd121);
        chk("t1_slot", 32'(spawnSlot), 32'd0);
        chk("t1_score", 32'(spawnScore), 32'd0);
        check_y("t1_y");
        do_ack();
        chk("t1_req_drop", 32'(spawnReq), 32'd0);
        wait_req(700, cyc);
        chk("t1_gap600", 32'(cyc), 32'd601);
        check_y("t1_y2");

        // 2) score-dependent interval
        score = 10'd40;
        do_ack();
        wait_req(300, cyc);
        chk("t2_gap_s40", 32'(cyc), 32'd181);
        chk("t2_score40", 32'(spawnScore), 32'd40);
        score = 10'd10;
        do_ack();
        wait_req(600, cyc);
        chk("t2_gap_s10", 32'(cyc), 32'd481);
        chk("t2_score10", 32'(spawnScore), 32'd10);

        // 3) all slots busy at expiry, then slot 1 frees
        score = 10'd40;
        slotBusy = 3'b111;
        do_ack();
        wait_req(250, cyc);
        chk("t3_busy_noreq", 32'(spawnReq), 32'd0);
        slotBusy = 3'b101;
        step(1);
        chk("t3_req", 32'(spawnReq), 32'd1);
        chk("t3_slot1", 32'(spawnSlot), 32'd1);
        check_y("t3_y");

        // 4) request held without ack, then enable drop and restart
        slotBusy = 3'b000;
        score = 10'd99;
        step(50);
        chk("t4_req_held", 32'(spawnReq), 32'd1);
        chk("t4_y_held", 32'(spawnY), lastExpY);
        chk("t4_score_held", 32'(spawnScore), 32'd40);
        chk("t4_slot_held", 32'(spawnSlot), 32'd1);
        enable = 1'b0;
        step(1);
        chk("t4_dis_req", 32'(spawnReq), 32'd0);
        chk("t4_dis_y_kept", 32'(spawnY), lastExpY);
        enable = 1'b1;
        step(1);
        wait_req(300, cyc);
        chk("t4_restart", 32'(cyc), 32'd121);
        chk("t4_score99", 32'(spawnScore), 32'd99);
        chk("t4_slot0", 32'(spawnSlot), 32'd0);

        // 5) async reset mid-request, then LFSR-driven Y sequence
        score = 10'd40;
        resetN = 1'b0;
        #1;
        chk("t5_async_req", 32'(spawnReq), 32'd0);
        chk("t5_async_y", 32'(spawnY), 32'd0);
        #3 resetN = 1'b1;
        step(1);
        wait_req(300, cyc);
        chk("t5_first", 32'(cyc), 32'd121);
        check_y("t5_y0");
        do_ack();
        wait_req(300, cyc);
        chk("t5_gap1", 32'(cyc), 32'd181);
        check_y("t5_y1");
        do_ack();
        wait_req(300, cyc);
        chk("t5_gap2", 32'(cyc), 32'd181);
        check_y("t5_y2");

`ifdef PIPE_SPAWN_MANUAL_EN
        // 6) manual spawn with clamped pointY
        do_ack();
        step(5);
        pointY = 10'd30;
        mouse1 = 1'b1;
        step(1);
        chk("t6_select_noreq", 32'(spawnReq), 32'd0);
        step(1);
        chk("t6_req_lo", 32'(spawnReq), 32'd1);
        chk("t6_y_lo", 32'(spawnY), 32'd112);
        mouse1 = 1'b0;
        do_ack();
        step(5);
        pointY = 10'd500;
        mouse1 = 1'b1;
        step(2);
        chk("t6_req_hi", 32'(spawnReq), 32'd1);
        chk("t6_y_hi", 32'(spawnY), 32'd367);
        mouse1 = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
